// File: rtl/reset_seq_pkg.sv
// Shared encodings for the reset sequencer: FSM states, reset cause codes and a sizing helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    StHold   = 2'd0,
    StStep   = 2'd1,
    StRun    = 2'd2,
    StSwHold = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_EXT = 2'd0;
  localparam logic [1:0] CAUSE_PG  = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_sync_bit.sv
// Single-bit synchronizer: a STAGES-deep flop chain cleared asynchronously by rst_n.
module rst_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: qualifies the supervisor reset with power-good and releases NRST domain
// resets in staggered order; re-enters reset on pg loss or a software request.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int unsigned NRST        = 4,
  parameter int unsigned T_HOLD      = 16,
  parameter int unsigned T_STEP      = 8,
  parameter int unsigned T_SW        = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pg,
  input  logic            sw_req,
  output logic [NRST-1:0] rst_out_n,
  output logic            done,
  output logic [1:0]      cause
);

  localparam int unsigned CW = $clog2(max3(T_HOLD, T_STEP, T_SW)) + 1;
  localparam int unsigned IW = (NRST > 1) ? $clog2(NRST) + 1 : 1;

  logic w_pg_s;
  logic w_sw_s;
  logic w_sw_rise;

  state_e          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [NRST-1:0] r_rst_out, w_rst_out_nxt;
  logic            r_done, w_done_nxt;
  logic [1:0]      r_cause, w_cause_nxt;
  logic            r_sw_d;

  rst_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync_pg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pg),
    .o_q   (w_pg_s)
  );

  rst_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (sw_req),
    .o_q   (w_sw_s)
  );

  assign w_sw_rise = w_sw_s & ~r_sw_d;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_rst_out_nxt = r_rst_out;
    w_done_nxt    = r_done;
    w_cause_nxt   = r_cause;

    unique case (r_state)
      StHold: begin
        if (!w_pg_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CW'(T_HOLD - 1)) begin
          w_rst_out_nxt[0] = 1'b1;
          w_cnt_nxt        = '0;
          w_idx_nxt        = IW'(1);
          w_state_nxt      = (NRST == 1) ? StRun : StStep;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      StStep: begin
        if (!w_pg_s) begin
          w_rst_out_nxt = '0;
          w_done_nxt    = 1'b0;
          w_cause_nxt   = CAUSE_PG;
          w_state_nxt   = StHold;
          w_cnt_nxt     = '0;
          w_idx_nxt     = '0;
        end else if (r_cnt == CW'(T_STEP - 1)) begin
          w_rst_out_nxt[r_idx] = 1'b1;
          w_cnt_nxt            = '0;
          if (r_idx == IW'(NRST - 1)) begin
            w_state_nxt = StRun;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      StRun: begin
        w_done_nxt = 1'b1;
        // pg loss takes priority over a coincident software request
        if (!w_pg_s) begin
          w_rst_out_nxt = '0;
          w_done_nxt    = 1'b0;
          w_cause_nxt   = CAUSE_PG;
          w_state_nxt   = StHold;
          w_cnt_nxt     = '0;
          w_idx_nxt     = '0;
        end else if (w_sw_rise) begin
          w_rst_out_nxt = '0;
          w_done_nxt    = 1'b0;
          w_cause_nxt   = CAUSE_SW;
          w_state_nxt   = StSwHold;
          w_cnt_nxt     = '0;
        end
      end
      StSwHold: begin
        if (r_cnt == CW'(T_SW - 1)) begin
          w_state_nxt = StHold;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = StHold;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StHold;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_out <= '0;
      r_done    <= 1'b0;
      r_cause   <= CAUSE_EXT;
      r_sw_d    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_rst_out <= w_rst_out_nxt;
      r_done    <= w_done_nxt;
      r_cause   <= w_cause_nxt;
      r_sw_d    <= w_sw_s;
    end
  end

  assign rst_out_n = r_rst_out;
  assign done      = r_done;
  assign cause     = r_cause;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: release timing table plus pg-loss, sw, reset and glitch cases.
module tb_reset_seq;
  import reset_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       pg;
  logic       sw_req;
  logic [3:0] rst_out_n;
  logic       done;
  logic [1:0] cause;

  int n_checks;
  int n_err;

  typedef struct {
    int         d;
    logic [3:0] rst;
    logic       dn;
  } vec_t;

  vec_t tbl [9];

  reset_seq #(
    .NRST        (4),
    .T_HOLD      (16),
    .T_STEP      (8),
    .T_SW        (32),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pg        (pg),
    .sw_req    (sw_req),
    .rst_out_n (rst_out_n),
    .done      (done),
    .cause     (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // d counts edges after the edge on which pg_s is first seen high by the FSM's HOLD count
  task automatic check_seq(input logic [1:0] exp_cause, input int last_d);
    for (int d = 1; d <= last_d; d++) begin
      tick();
      for (int k = 0; k < 9; k++) begin
        if (tbl[k].d == d) begin
          chk($sformatf("seq_rst_d%0d", d), 8'(rst_out_n), 8'(tbl[k].rst));
          chk($sformatf("seq_done_d%0d", d), 8'(done), 8'(tbl[k].dn));
          chk($sformatf("seq_cause_d%0d", d), 8'(cause), 8'(exp_cause));
        end
      end
    end
  endtask

  // Software request from RUN; returns on the edge where SWHOLD hands back to HOLD
  task automatic sw_pulse();
    @(negedge clk);
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    tick();
    tick();
    chk("sw_abort_rst", 8'(rst_out_n), 8'h0);
    chk("sw_abort_done", 8'(done), 8'h0);
    chk("sw_abort_cause", 8'(cause), 8'(CAUSE_SW));
    for (int i = 3; i <= 34; i++) begin
      if (i == 9) sw_req = 1'b1;
      if (i == 11) sw_req = 1'b0;
      tick();
    end
    chk("swhold_end_rst", 8'(rst_out_n), 8'h0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    tbl[0] = '{d: 15, rst: 4'b0000, dn: 1'b0};
    tbl[1] = '{d: 16, rst: 4'b0001, dn: 1'b0};
    tbl[2] = '{d: 23, rst: 4'b0001, dn: 1'b0};
    tbl[3] = '{d: 24, rst: 4'b0011, dn: 1'b0};
    tbl[4] = '{d: 31, rst: 4'b0011, dn: 1'b0};
    tbl[5] = '{d: 32, rst: 4'b0111, dn: 1'b0};
    tbl[6] = '{d: 39, rst: 4'b0111, dn: 1'b0};
    tbl[7] = '{d: 40, rst: 4'b1111, dn: 1'b0};
    tbl[8] = '{d: 41, rst: 4'b1111, dn: 1'b1};

    rst_n  = 1'b0;
    pg     = 1'b1;
    sw_req = 1'b0;
    tick();
    tick();
    chk("reset_rst", 8'(rst_out_n), 8'h0);
    chk("reset_done", 8'(done), 8'h0);
    chk("reset_cause", 8'(cause), 8'(CAUSE_EXT));

    // Power-up sequence: stage 0 at edge 18, done at edge 43
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check_seq(CAUSE_EXT, 41);

    // One-cycle pg drop in RUN
    @(negedge clk);
    pg = 1'b0;
    @(negedge clk);
    pg = 1'b1;
    tick();
    chk("pg_drop_not_yet", 8'(rst_out_n), 8'hf);
    tick();
    chk("pg_abort_rst", 8'(rst_out_n), 8'h0);
    chk("pg_abort_done", 8'(done), 8'h0);
    chk("pg_abort_cause", 8'(cause), 8'(CAUSE_PG));
    check_seq(CAUSE_PG, 41);

    // Software reset with a second request ignored inside SWHOLD
    sw_pulse();
    check_seq(CAUSE_SW, 41);

    // pg loss and sw request on the same edge: pg wins, no SWHOLD
    @(negedge clk);
    pg     = 1'b0;
    sw_req = 1'b1;
    @(negedge clk);
    pg     = 1'b1;
    sw_req = 1'b0;
    tick();
    tick();
    chk("both_rst", 8'(rst_out_n), 8'h0);
    chk("both_cause", 8'(cause), 8'(CAUSE_PG));
    check_seq(CAUSE_PG, 41);

    // Async rst_n drop mid-STEP after 0011
    sw_pulse();
    check_seq(CAUSE_SW, 24);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 8'(rst_out_n), 8'h0);
    chk("async_done", 8'(done), 8'h0);
    chk("async_cause", 8'(cause), 8'(CAUSE_EXT));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check_seq(CAUSE_EXT, 41);

    // pg glitch in HOLD at cnt=10 restarts the hold count
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) tick();
    @(negedge clk);
    pg = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clk);
    pg = 1'b1;
    tick();
    tick();
    chk("glitch_hold_rst", 8'(rst_out_n), 8'h0);
    check_seq(CAUSE_EXT, 41);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
